sel_encode_unit: RTL and testbench
==================================

// Module: sel_encode_unit
// PURPOSE
//  Registered, parametrised select-and-encode stage for the register file of the RISC datapath.
//  - Keeps a shadow copy of IR.
//  - Picks the Ra/Rb/Rc field using the Gra/Grb/Grc strobes.
//  - Drives one-hot Rin/Rout enables to the register file.
//  - Drives the sign-extended C constant onto the bus path.
//  - Adds over the previous gen: sticky selection hold, BAout R0-as-zero, multi-strobe conflict flag.
// PARAMETERS
//  DATA_W    32  datapath / IR width
//  REG_COUNT 16  number of GPRs (power of 2)
//  SEL_W     4   register index width, = log2(REG_COUNT)
//  RA_LSB    23  LSB of Ra field in IR (field is SEL_W bits)
//  RB_LSB    19  LSB of Rb field
//  RC_LSB    15  LSB of Rc field
//  C_W       19  width of C constant, IR[C_W-1:0]; sign bit IR[C_W-1]
// PORTS
//  clock          in   1          rising-edge clock
//  reset          in   1          synchronous, active-high
//  ir_load        in   1          capture ir_in into shadow IR
//  ir_in          in   DATA_W     IR value from bus
//  gra,grb,grc    in   1 each     field select strobes
//  rin            in   1          write-enable request for selected reg
//  rout           in   1          read-enable request for selected reg
//  baout          in   1          base-address read (R0 reads as zero)
//  r_in_en        out  REG_COUNT  one-hot register write enables
//  r_out_en       out  REG_COUNT  one-hot register read enables
//  r0_zero        out  1          drive zero on bus in place of R0
//  sel_idx        out  SEL_W      currently held register index
//  sel_conflict   out  1          >1 of gra/grb/grc asserted last cycle
//  c_sign_ext     out  DATA_W     sign-extended IR[C_W-1:0] from shadow IR
// BEHAVIOUR
//  - Reset: all outputs, shadow IR and sel_idx clear to 0 on the first edge with reset=1.
//    Reset overrides every other input, including mid-operation.
//  - Shadow IR: loads ir_in on an edge with ir_load=1, otherwise holds.
//    Field decode and c_sign_ext use only the shadow IR, never ir_in.
//    If ir_load and gr* are asserted in the same cycle, the field comes from the OLD shadow IR.
//  - Selection priority: grc > grb > gra.
//    Next sel_idx = IR[RC_LSB+:SEL_W] / IR[RB_LSB+:SEL_W] / IR[RA_LSB+:SEL_W].
//    With no strobe, sel_idx holds its value (sticky).
//  - Enables are registered, 1-cycle latency from inputs.
//    Decode uses next_sel, i.e. same-cycle strobes count.
//    r_in_en  <= rin ? onehot(next_sel) : 0
//    r_out_en <= (rout | (baout & next_sel!=0)) ? onehot(next_sel) : 0
//    r0_zero  <= baout & ~rout & (next_sel==0)
//    If rout and baout are both high with sel 0, rout wins: r_out_en[0]=1, r0_zero=0.
//  - At most one bit set in each of r_in_en and r_out_en.
//    rin and rout in the same cycle are legal: both vectors carry the same one-hot bit.
//  - sel_conflict <= popcount(gra,grb,grc)>1. 1-cycle pulse; priority still applies.
//  - c_sign_ext <= {{(DATA_W-C_W){shIR[C_W-1]}}, shIR[C_W-1:0]}, where shIR is the post-load value.
//    Valid in the cycle after ir_load.
//  - Out-of-range index cannot occur (REG_COUNT = 2^SEL_W).
// TESTING
//  T1 Load + C field: ir_load, ir_in=0x02C90123.
//     -> next cycle c_sign_ext=0x00010123.
//     Then ir_in=0x0007FFFF -> c_sign_ext=0xFFFFFFFF.
//  T2 Field select: after 0x02C90123 loaded, gra+rin -> r_in_en=0x0020, sel_idx=5.
//     grb+rout -> r_out_en=0x0200. grc+rout -> r_out_en=0x0004.
//  T3 Sticky + conflict: grb pulse, then 3 cycles of rout only -> r_out_en=0x0200 each cycle.
//     gra+grc together -> sel_idx=2, sel_conflict=1 for one cycle.
//  T4 BAout: IR with Ra=0, gra+baout -> r0_zero=1, r_out_en=0.
//     Same with Ra=7 -> r_out_en=0x0080, r0_zero=0.
//     rout+baout with Ra=0 -> r_out_en=0x0001.
//  T5 Load/select same cycle: shadow holds Ra=5; ir_load(Ra=3)+gra+rin -> r_in_en=0x0020.
//     Next gra+rin -> r_in_en=0x0008.
//  T6 Reset mid-op: reset with rin/gra/ir_load high -> next cycle all outputs 0, sel_idx=0.
//     rin alone after reset -> r_in_en=0x0001.

Source files
------------

// File: rtl/sel_encode_unit.sv
// Registered select-and-encode stage: shadow IR, Ra/Rb/Rc field selection,
// one-hot register file enables and sign-extended C constant.
module sel_encode_unit #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 16,
  parameter int SEL_W     = 4,
  parameter int RA_LSB    = 23,
  parameter int RB_LSB    = 19,
  parameter int RC_LSB    = 15,
  parameter int C_W       = 19
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ir_load,
  input  logic [DATA_W-1:0]    ir_in,
  input  logic                 gra,
  input  logic                 grb,
  input  logic                 grc,
  input  logic                 rin,
  input  logic                 rout,
  input  logic                 baout,
  output logic [REG_COUNT-1:0] r_in_en,
  output logic [REG_COUNT-1:0] r_out_en,
  output logic                 r0_zero,
  output logic [SEL_W-1:0]     sel_idx,
  output logic                 sel_conflict,
  output logic [DATA_W-1:0]    c_sign_ext
);

  logic [DATA_W-1:0] sh_ir_r;
  logic [DATA_W-1:0] sh_ir_next_s;
  logic [SEL_W-1:0]  next_sel_s;
  logic [1:0]        strobe_cnt_s;
  logic              out_req_s;

  function automatic logic [REG_COUNT-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = {{(REG_COUNT-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Next selection, post-load shadow IR and strobe count; fields come from the old shadow IR.
  always_comb begin
    sh_ir_next_s = sh_ir_r;
    next_sel_s   = sel_idx;
    if (ir_load) begin
      sh_ir_next_s = ir_in;
    end else begin
      sh_ir_next_s = sh_ir_r;
    end
    if (grc) begin
      next_sel_s = sh_ir_r[RC_LSB +: SEL_W];
    end else if (grb) begin
      next_sel_s = sh_ir_r[RB_LSB +: SEL_W];
    end else if (gra) begin
      next_sel_s = sh_ir_r[RA_LSB +: SEL_W];
    end else begin
      next_sel_s = sel_idx;
    end
    strobe_cnt_s = {1'b0, gra} + {1'b0, grb} + {1'b0, grc};
    out_req_s    = rout | (baout & (next_sel_s != {SEL_W{1'b0}}));
  end

  // All state and outputs registered; reset overrides every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_ir_r      <= {DATA_W{1'b0}};
      sel_idx      <= {SEL_W{1'b0}};
      r_in_en      <= {REG_COUNT{1'b0}};
      r_out_en     <= {REG_COUNT{1'b0}};
      r0_zero      <= 1'b0;
      sel_conflict <= 1'b0;
      c_sign_ext   <= {DATA_W{1'b0}};
    end else begin
      sh_ir_r      <= sh_ir_next_s;
      sel_idx      <= next_sel_s;
      r_in_en      <= rin ? onehot(next_sel_s) : {REG_COUNT{1'b0}};
      r_out_en     <= out_req_s ? onehot(next_sel_s) : {REG_COUNT{1'b0}};
      // rout takes precedence over the R0-as-zero substitution
      r0_zero      <= baout & ~rout & (next_sel_s == {SEL_W{1'b0}});
      sel_conflict <= (strobe_cnt_s > 2'd1);
      c_sign_ext   <= {{(DATA_W-C_W){sh_ir_next_s[C_W-1]}}, sh_ir_next_s[C_W-1:0]};
    end
  end

endmodule

// File: tb/tb_sel_encode_unit.sv
// Self-checking bench for sel_encode_unit: directed scenarios plus randomized
// stimulus compared against a behavioural model every cycle.
module tb_sel_encode_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ir_load;
  logic [31:0] ir_in;
  logic        gra, grb, grc, rin, rout, baout;
  logic [15:0] r_in_en, r_out_en;
  logic        r0_zero;
  logic [3:0]  sel_idx;
  logic        sel_conflict;
  logic [31:0] c_sign_ext;

  int tests_run = 0;
  int tests_failed = 0;

  // model state
  logic [31:0] m_ir;
  int          m_sel;
  logic [15:0] m_rin_en, m_rout_en;
  logic        m_r0, m_conf;
  logic [31:0] m_c;

  sel_encode_unit dut (
    .clock(clock), .reset(reset), .ir_load(ir_load), .ir_in(ir_in),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .r_in_en(r_in_en), .r_out_en(r_out_en), .r0_zero(r0_zero),
    .sel_idx(sel_idx), .sel_conflict(sel_conflict), .c_sign_ext(c_sign_ext)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int field(input logic [31:0] ir, input int lsb);
    return int'((ir >> lsb) & 32'd15);
  endfunction

  function automatic logic [31:0] sext19(input logic [31:0] ir);
    longint v;
    v = longint'(ir & 32'h0007FFFF);
    if (v >= 64'sd262144) v = v - 64'sd524288;
    return v[31:0];
  endfunction

  task automatic model_update();
    int nsel;
    int cnt;
    if (reset) begin
      m_ir = 32'd0; m_sel = 0; m_rin_en = 16'd0; m_rout_en = 16'd0;
      m_r0 = 1'b0; m_conf = 1'b0; m_c = 32'd0;
    end else begin
      if (grc)      nsel = field(m_ir, 15);
      else if (grb) nsel = field(m_ir, 19);
      else if (gra) nsel = field(m_ir, 23);
      else          nsel = m_sel;
      if (ir_load) m_ir = ir_in;
      m_sel     = nsel;
      m_rin_en  = rin ? 16'(1 << nsel) : 16'd0;
      m_rout_en = (rout || (baout && nsel != 0)) ? 16'(1 << nsel) : 16'd0;
      m_r0      = baout && !rout && nsel == 0;
      cnt       = int'(gra) + int'(grb) + int'(grc);
      m_conf    = cnt > 1;
      m_c       = sext19(m_ir);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    chk("model_r_in_en",  {16'd0, r_in_en},  {16'd0, m_rin_en});
    chk("model_r_out_en", {16'd0, r_out_en}, {16'd0, m_rout_en});
    chk("model_r0_zero",  {31'd0, r0_zero},  {31'd0, m_r0});
    chk("model_sel_idx",  {28'd0, sel_idx},  32'(m_sel));
    chk("model_conflict", {31'd0, sel_conflict}, {31'd0, m_conf});
    chk("model_c_sext",   c_sign_ext, m_c);
  endtask

  task automatic drive(input logic ld, input logic [31:0] irv, input logic a, input logic b,
                       input logic c, input logic ri, input logic ro, input logic ba);
    ir_load = ld; ir_in = irv; gra = a; grb = b; grc = c; rin = ri; rout = ro; baout = ba;
    step();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_r_in_en", {16'd0, r_in_en}, 32'd0);
    chk("reset_sel_idx", {28'd0, sel_idx}, 32'd0);
    chk("reset_c", c_sign_ext, 32'd0);
    reset = 1'b0;

    // T1
    drive(1'b1, 32'h02C90123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_c_pos", c_sign_ext, 32'h00010123);
    drive(1'b1, 32'h0007FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_c_neg", c_sign_ext, 32'hFFFFFFFF);
    drive(1'b1, 32'h02C90123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // T2
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_ra_rin", {16'd0, r_in_en}, 32'h0020);
    chk("t2_ra_idx", {28'd0, sel_idx}, 32'd5);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_rb_rout", {16'd0, r_out_en}, 32'h0200);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2_rc_rout", {16'd0, r_out_en}, 32'h0004);
    // T3
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t3_sticky", {16'd0, r_out_en}, 32'h0200);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_conf_idx", {28'd0, sel_idx}, 32'd2);
    chk("t3_conf", {31'd0, sel_conflict}, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_conf_pulse", {31'd0, sel_conflict}, 32'd0);
    // T4
    drive(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_r0_zero", {31'd0, r0_zero}, 32'd1);
    chk("t4_r0_rout", {16'd0, r_out_en}, 32'd0);
    drive(1'b1, 32'h03800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_r7_rout", {16'd0, r_out_en}, 32'h0080);
    chk("t4_r7_zero", {31'd0, r0_zero}, 32'd0);
    drive(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4_both_rout", {16'd0, r_out_en}, 32'h0001);
    chk("t4_both_zero", {31'd0, r0_zero}, 32'd0);
    // T5
    drive(1'b1, 32'h02C90123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h01800000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_old_ir", {16'd0, r_in_en}, 32'h0020);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_new_ir", {16'd0, r_in_en}, 32'h0008);
    // T6
    reset = 1'b1;
    drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_rst_rin", {16'd0, r_in_en}, 32'd0);
    chk("t6_rst_idx", {28'd0, sel_idx}, 32'd0);
    chk("t6_rst_c", c_sign_ext, 32'd0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_rin_r0", {16'd0, r_in_en}, 32'h0001);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive(($urandom_range(0, 3) == 0), $urandom,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
